cxapbasyncbridge_cdc_launch_fifo: RTL
=====================================

Name: cxapbasyncbridge_cdc_launch_fifo

Overview:
- Write-domain half of an asynchronous FIFO for the APB async bridge.
- Holds DEPTH launch slots of WIDTH bits; each slot is a register loaded only when that slot is written.
- Slots and a Gray-coded write pointer are driven to the read domain; the read domain's Gray pointer comes back already synchronised.
- Generates full/ready and a fill level locally.

Parameters:
- WIDTH, 32: bits per data slot (>=1).
- ADDR_W, 2: slot index width; DEPTH = 2**ADDR_W (ADDR_W >= 1).

Ports:
- clk  input  1  write-domain clock.
- resetn  input  1  reset, asynchronous, active-low.
- wr_valid  input  1  write request.
- wr_ready  output  1  slot available (= not full).
- wr_data  input  WIDTH  write data.
- rptr_gray_sync  input  ADDR_W+1  read pointer, Gray-coded, already synchronised into clk.
- wr_level  output  ADDR_W+1  occupancy as seen from the write side, 0..DEPTH.
- data_async  output  DEPTH*WIDTH  all slots concatenated; slot i is bits [i*WIDTH +: WIDTH].
- wptr_gray_async  output  ADDR_W+1  write pointer, Gray-coded, registered, for the read-domain synchroniser.

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed):
  - all slots 0; binary write pointer 0; wptr_gray_async 0.
  - Outputs during and after reset: wr_ready=1, wr_level=0.
- Accept: wr_valid & wr_ready at a rising clk edge.
  - slot[wptr_bin[ADDR_W-1:0]] <= wr_data.
  - wptr_bin <= wptr_bin+1, modulo 2**(ADDR_W+1).
  - wptr_gray_async <= bin2gray(wptr_bin+1).
  - Slot data and pointer update on the same edge, with a 1-cycle launch latency.
  - wptr_gray_async changes exactly one bit per accept.
- No accept: slots and pointers hold. Unwritten slots never toggle.
- wr_valid while full: ignored, no state change, no error flag.
- Full: wptr_gray_async == {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]}.
  - For ADDR_W=1, the comparison is {~rptr[1:0]}.
- wr_ready = ~full. Combinational from registers and rptr_gray_sync only; no dependence on wr_valid.
- wr_level = (wptr_bin - gray2bin(rptr_gray_sync)) mod 2**(ADDR_W+1).
  - Combinational; equals DEPTH exactly when full, 0 when empty.
- Wrap-around: the pointer wraps from 2**(ADDR_W+1)-1 to 0. Full/level stay correct across the wrap.
- Simultaneous accept and rptr_gray_sync change: full/level for the next cycle use the new values of both. An accept is judged on the current-cycle wr_ready only.
- Read pointer moves only toward wptr. A pointer implying level > DEPTH is illegal; bench asserts on it, RTL output is unspecified.
- Reset mid-operation: immediate clear of all state regardless of clk. Both bridge domains must be reset together; a one-sided reset is a system error.
- CDC rules:
  - data_async and wptr_gray_async come straight from flops; no combinational logic after the launch flops.
  - A slot is never written while it is occupied (guaranteed by full).

Decomposition:
- Shared package cxapbasyncbridge_pkg: bin2gray and gray2bin functions, parameterised on width.
- Sub-module cxapbasyncbridge_cdc_launch_gray: WIDTH-generic binary counter plus registered Gray output with increment enable. Instantiated once for the write pointer; reusable for the read side.
- Slot array: generate loop in this module.

Test Plan (WIDTH=8, ADDR_W=2):
- Reset: assert resetn=0 mid-stream after 3 writes -> wr_ready=1, wr_level=0, data_async=0, wptr_gray_async=3'b000 immediately.
- Fill: rptr=0, write 0x11,0x22,0x33,0x44 on consecutive cycles -> wptr_gray_async 001,011,010,110; wr_level 1..4; wr_ready=0 after the 4th; data_async=0x44332211.
- Write while full: wr_valid=1, wr_data=0x55 with rptr=0 -> no change in data_async or pointer; wr_ready stays 0.
- Drain and wrap: rptr_gray_sync=010 (bin 3) -> wr_level=1, wr_ready=1. Write 0x66,0x77,0x88 -> slot0=0x66, slot1=0x77, slot2=0x88, wptr_bin=7 (gray 100), full. Set rptr=100 -> empty. One more write -> pointer wraps to 0 (gray 000).
- Simultaneous: at full (wptr 4, rptr 0), rptr moves to 001 on the same edge as wr_valid=1 -> no accept that cycle; next cycle wr_ready=1, wr_level=3.
- Gray property: random valid/rptr traffic for 10k cycles -> every wptr_gray_async change has Hamming distance 1; an unaccepted cycle never changes any slot.

Source files
------------

// File: rtl/cxapbasyncbridge_pkg.sv
// Shared helpers for the APB async bridge CDC FIFO halves.
// Gray/binary conversion on a fixed maximum width; callers zero-extend and truncate.
package cxapbasyncbridge_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits stay zero through the prefix XOR, so narrower pointers convert correctly.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
            b[GRAY_MAX_W-1-i] = b[GRAY_MAX_W-i] ^ g[GRAY_MAX_W-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cxapbasyncbridge_cdc_launch_gray.sv
// Binary pointer with a registered Gray copy for launching across a clock domain.
// WIDTH must not exceed cxapbasyncbridge_pkg::GRAY_MAX_W.
module cxapbasyncbridge_cdc_launch_gray
    import cxapbasyncbridge_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] bin_next;

    always_comb begin
        bin_next = bin + WIDTH'(1);
    end

    // Gray is computed from the next binary value so it is a flop output, never decoded logic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin  <= '0;
            gray <= '0;
        end else if (inc) begin
            bin  <= bin_next;
            gray <= WIDTH'(bin2gray(gray_word_t'(bin_next)));
        end
    end

endmodule

// File: rtl/cxapbasyncbridge_cdc_launch_fifo.sv
// Write-domain half of the APB async bridge FIFO: launch slots, Gray write pointer,
// and local full/level derived from the synchronised read pointer.
module cxapbasyncbridge_cdc_launch_fifo
    import cxapbasyncbridge_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [ADDR_W:0]              rptr_gray_sync,
    output logic [ADDR_W:0]              wr_level,
    output logic [(2**ADDR_W)*WIDTH-1:0] data_async,
    output logic [ADDR_W:0]              wptr_gray_async
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;
    // Full when the top two Gray bits differ from the read pointer and the rest match.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] rptr_bin;
    logic          full;
    logic          accept;

    cxapbasyncbridge_cdc_launch_gray #(
        .WIDTH (PW)
    ) u_wptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (accept),
        .bin    (wptr_bin),
        .gray   (wptr_gray_async)
    );

    always_comb begin
        rptr_bin = PW'(gray2bin(gray_word_t'(rptr_gray_sync)));
        full     = (wptr_gray_async == (rptr_gray_sync ^ FULL_MASK));
        wr_ready = ~full;
        wr_level = wptr_bin - rptr_bin;
        accept   = wr_valid & wr_ready;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [WIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                slot_q <= '0;
            end else if (accept && (wptr_bin[ADDR_W-1:0] == ADDR_W'(i))) begin
                slot_q <= wr_data;
            end
        end

        assign data_async[i*WIDTH +: WIDTH] = slot_q;
    end

endmodule
